// File: rtl/cpu_trace_monitor_if.sv
// Retire-stage tap and trace read port shared by the core side and the trace monitor.
//   master : drives the retire tap (en, pc, next_pc, instr, zero_flag, check_val) and rd_en;
//            receives rd_data / rd_valid.
//   slave  : the monitor; consumes the tap and rd_en, drives rd_data / rd_valid.
// rd_data is packed {pc, instr, zero_flag}.
interface cpu_trace_monitor_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DATA_W  = 16
);
  logic                     en;
  logic [PC_W-1:0]          pc;
  logic [PC_W-1:0]          next_pc;
  logic [INSTR_W-1:0]       instr;
  logic                     zero_flag;
  logic [DATA_W-1:0]        check_val;
  logic                     rd_en;
  logic [PC_W+INSTR_W:0]    rd_data;
  logic                     rd_valid;

  modport master (
    output en, pc, next_pc, instr, zero_flag, check_val, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  en, pc, next_pc, instr, zero_flag, check_val, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/cpu_trace_monitor.sv
// In-design monitor for the cpu retire stage.
// Captures a FIFO trace of {pc, instr, zero_flag}, counts active cycles, detects a halt as
// HALT_CONFIRM consecutive jump-to-self retires and then grades check_val against EXPECT.
// Reports TIMEOUT if no halt is confirmed within TIMEOUT_CYC active cycles.
// Ports:
//   clk, rst (async, active-low), clear (sync restart, overrides everything but rst)
//   bus         : retire tap + first-word-fall-through trace read port (slave modport)
//   trace_count : valid trace entries (0..DEPTH)
//   overflow    : sticky, an entry was lost (overwritten with WRAP=1, dropped with WRAP=0)
//   cycle_count : saturating count of cycles spent in RUN or HALT_PEND
//   state       : RUN=0, HALT_PEND=1, PASS=2, FAIL=3, TIMEOUT=4
//   done, pass  : terminal-state decodes
//   hist_sel, hist_count : opcode histogram read
// Optional feature: define CPU_TRACE_MONITOR_OPCODE_HIST_EN to build 16 per-opcode retire
// counters; otherwise hist_count is tied to 0.
module cpu_trace_monitor #(
  parameter int unsigned       PC_W         = 16,
  parameter int unsigned       INSTR_W      = 16,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       DEPTH        = 8,
  parameter int unsigned       CNT_W        = 16,
  parameter int unsigned       HALT_CONFIRM = 2,
  parameter int unsigned       TIMEOUT_CYC  = 100,
  parameter logic [DATA_W-1:0] EXPECT       = '0,
  parameter bit                WRAP         = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  cpu_trace_monitor_if.slave       bus,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [2:0]               state,
  output logic                     done,
  output logic                     pass,
  input  logic [3:0]               hist_sel,
  output logic [CNT_W-1:0]         hist_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = PC_W + INSTR_W + 1;
  localparam int unsigned RUN_W   = $clog2(HALT_CONFIRM + 1);

  localparam logic [PTR_W:0]     FullCount   = (PTR_W+1)'(DEPTH);
  localparam logic [RUN_W-1:0]   ConfirmRun  = RUN_W'(HALT_CONFIRM);
  localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StHaltPend = 3'd1,
    StPass     = 3'd2,
    StFail     = 3'd3,
    StTimeout  = 3'd4
  } state_e;

  state_e               state_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q, count_d;
  logic                 overflow_q;
  logic [CNT_W-1:0]     cycle_q;
  logic [RUN_W-1:0]     run_q, run_next;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];

  logic active, push_req, pop, full, discard, do_write, lost, self_loop, confirm, timeout_hit;
  logic [ENTRY_W-1:0] entry;

  assign active    = (state_q == StRun) || (state_q == StHaltPend);
  assign push_req  = bus.en & active;
  assign pop       = bus.rd_en & (count_q != '0);
  assign full      = (count_q == FullCount);
  // Full with no simultaneous pop: WRAP overwrites the oldest slot, otherwise the push is lost.
  assign lost      = push_req & full & ~pop;
  assign discard   = lost & WRAP;
  assign do_write  = push_req & (~full | pop | WRAP);
  assign entry     = {bus.pc, bus.instr, bus.zero_flag};

  assign self_loop   = bus.next_pc == bus.pc;
  assign run_next    = run_q + RUN_W'(1);
  assign confirm     = push_req & self_loop & (run_next == ConfirmRun);
  assign timeout_hit = active & (cycle_q == TimeoutLast);

  always_comb begin
    count_d = count_q;
    if (do_write) count_d = count_d + (PTR_W+1)'(1);
    if (pop || discard) count_d = count_d - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      run_q      <= '0;
    end else if (clear) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      run_q      <= '0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop || discard) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (lost) overflow_q <= 1'b1;
      if (active && (cycle_q != '1)) cycle_q <= cycle_q + CNT_W'(1);
      if (push_req) run_q <= self_loop ? run_next : '0;
      if (active) begin
        // A confirmed halt takes precedence over a timeout on the same edge.
        if (confirm) begin
          state_q <= (bus.check_val == EXPECT) ? StPass : StFail;
        end else if (timeout_hit) begin
          state_q <= StTimeout;
        end else if (bus.en) begin
          state_q <= self_loop ? StHaltPend : StRun;
        end
      end
    end
  end

  // Trace storage needs no reset: contents are only observed while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (do_write && !clear) mem_q[wr_ptr_q] <= entry;
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign trace_count  = count_q;
  assign overflow     = overflow_q;
  assign cycle_count  = cycle_q;
  assign state        = state_q;
  assign done         = (state_q == StPass) || (state_q == StFail) || (state_q == StTimeout);
  assign pass         = (state_q == StPass);

`ifdef CPU_TRACE_MONITOR_OPCODE_HIST_EN
  logic [CNT_W-1:0] hist_q [16];
  logic [3:0]       opcode;

  assign opcode = bus.instr[INSTR_W-1 -: 4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) hist_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 16; i++) hist_q[i] <= '0;
    end else if (push_req && (hist_q[opcode] != '1)) begin
      hist_q[opcode] <= hist_q[opcode] + CNT_W'(1);
    end
  end

  assign hist_count = hist_q[hist_sel];
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel;
  assign hist_count      = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor. Two instances share one stimulus stream: one
// with WRAP=1 and one with WRAP=0. A queue-based reference model tracks the expected trace,
// overflow flags, cycle count and monitor state.
module tb_cpu_trace_monitor;
  localparam int unsigned PC_W = 16, INSTR_W = 16, DATA_W = 16, DEPTH = 8, CNT_W = 16;
  localparam int unsigned HALT_CONFIRM = 2, TIMEOUT_CYC = 100;
  localparam int unsigned ENTRY_W = PC_W + INSTR_W + 1;
  localparam logic [DATA_W-1:0] EXPECT = '0;
  typedef logic [ENTRY_W-1:0] entry_t;

  logic clk = 1'b0, rst = 1'b0, clear = 1'b0;
  logic en = 1'b0, zero_flag = 1'b0, rd_en = 1'b0;
  logic [PC_W-1:0] pc = '0, next_pc = '0;
  logic [INSTR_W-1:0] instr = '0;
  logic [DATA_W-1:0] check_val = '0;
  logic [3:0] hist_sel = '0;

  logic [3:0] w_count, n_count;
  logic w_ovf, n_ovf, w_done, n_done, w_pass, n_pass;
  logic [CNT_W-1:0] w_cycle, n_cycle, w_hist, n_hist;
  logic [2:0] w_state, n_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_trace_monitor_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) bus_w ();
  cpu_trace_monitor_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) bus_n ();

  assign bus_w.en = en;           assign bus_n.en = en;
  assign bus_w.pc = pc;           assign bus_n.pc = pc;
  assign bus_w.next_pc = next_pc; assign bus_n.next_pc = next_pc;
  assign bus_w.instr = instr;     assign bus_n.instr = instr;
  assign bus_w.zero_flag = zero_flag;
  assign bus_n.zero_flag = zero_flag;
  assign bus_w.check_val = check_val;
  assign bus_n.check_val = check_val;
  assign bus_w.rd_en = rd_en;     assign bus_n.rd_en = rd_en;

  cpu_trace_monitor #(.WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus_w), .trace_count(w_count),
    .overflow(w_ovf), .cycle_count(w_cycle), .state(w_state), .done(w_done), .pass(w_pass),
    .hist_sel(hist_sel), .hist_count(w_hist)
  );

  cpu_trace_monitor #(.WRAP(1'b0)) dut_n (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus_n), .trace_count(n_count),
    .overflow(n_ovf), .cycle_count(n_cycle), .state(n_state), .done(n_done), .pass(n_pass),
    .hist_sel(hist_sel), .hist_count(n_hist)
  );

  // Reference model: state numbering RUN=0 HALT_PEND=1 PASS=2 FAIL=3 TIMEOUT=4.
  entry_t q_w[$];
  entry_t q_n[$];
  bit m_ovf_w, m_ovf_n;
  int m_state, m_cycle, m_run;

  task automatic model_reset();
    q_w.delete(); q_n.delete();
    m_ovf_w = 0; m_ovf_n = 0;
    m_state = 0; m_cycle = 0; m_run = 0;
  endtask

  task automatic model_edge();
    bit act, push, pw, pn, fw, fn, halted;
    entry_t e;
    int nxt;
    if (clear) begin
      model_reset();
      return;
    end
    act = (m_state == 0) || (m_state == 1);
    push = en && act;
    e = {pc, instr, zero_flag};
    pw = rd_en && (q_w.size() != 0);
    fw = (q_w.size() == DEPTH);
    pn = rd_en && (q_n.size() != 0);
    fn = (q_n.size() == DEPTH);
    if (pw) void'(q_w.pop_front());
    if (pn) void'(q_n.pop_front());
    if (push) begin
      if (fw && !pw) begin
        m_ovf_w = 1;
        void'(q_w.pop_front());
      end
      q_w.push_back(e);
      if (fn && !pn) m_ovf_n = 1;
      else q_n.push_back(e);
    end
    if (act) begin
      nxt = m_state;
      halted = 0;
      if (en) begin
        if (next_pc == pc) begin
          m_run++;
          nxt = 1;
          if (m_run >= HALT_CONFIRM) begin
            halted = 1;
            nxt = (check_val == EXPECT) ? 2 : 3;
          end
        end else begin
          m_run = 0;
          nxt = 0;
        end
      end
      if (!halted && (m_cycle == TIMEOUT_CYC - 1)) nxt = 4;
      if (m_cycle < 65535) m_cycle++;
      m_state = nxt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic retire(input int p, input int np, input int op, input int cv);
    en = 1'b1;
    pc = PC_W'(p);
    next_pc = PC_W'(np);
    instr = {op[3:0], 12'($urandom)};
    zero_flag = 1'($urandom);
    check_val = DATA_W'(cv);
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++; if (w_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", w_state); end
    checks++; if (w_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", w_count); end
    checks++; if (bus_w.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus_w.rd_valid); end
    checks++; if (bus_w.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus_w.rd_data); end
    checks++; if (w_cycle !== '0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", w_cycle); end
    checks++; if (w_done !== 1'b0 || w_pass !== 1'b0) begin failures++; $display("FAIL reset_done_pass got=%b%b exp=00", w_done, w_pass); end
    checks++; if (w_ovf !== 1'b0 || n_ovf !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b%b exp=00", w_ovf, n_ovf); end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_halt_pass();
    do_clear();
    retire(0, 1, 0, 0);
    retire(1, 2, 1, 0);
    retire(2, 3, 2, 0);
    checks++; if (w_state !== 3'd0) begin failures++; $display("FAIL pass_run_state got=%0d exp=0", w_state); end
    retire(3, 3, 7, 0);
    checks++; if (w_state !== 3'd1) begin failures++; $display("FAIL pass_pend_state got=%0d exp=1", w_state); end
    retire(3, 3, 7, 0);
    checks++; if (w_state !== 3'd2) begin failures++; $display("FAIL pass_state got=%0d exp=2", w_state); end
    checks++; if (w_done !== 1'b1 || w_pass !== 1'b1) begin failures++; $display("FAIL pass_done_pass got=%b%b exp=11", w_done, w_pass); end
    checks++; if (w_count !== 4'd5) begin failures++; $display("FAIL pass_count got=%0d exp=5", w_count); end
    checks++; if (w_cycle !== 16'd5) begin failures++; $display("FAIL pass_cycle got=%0d exp=5", w_cycle); end
    en = 1'b1;  // retires after the halt must not be traced
    pc = 16'h55; next_pc = 16'h56;
    repeat (3) tick();
    en = 1'b0;
    checks++; if (w_cycle !== 16'd5) begin failures++; $display("FAIL pass_cycle_frozen got=%0d exp=5", w_cycle); end
    checks++; if (w_count !== 4'd5) begin failures++; $display("FAIL pass_no_push got=%0d exp=5", w_count); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_w.rd_data !== q_w[0] || bus_w.rd_data[ENTRY_W-1 -: PC_W] !== PC_W'(i > 3 ? 3 : i)) begin
        failures++;
        $display("FAIL pass_drain[%0d] got=%h exp=%h", i, bus_w.rd_data, q_w[0]);
      end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    checks++; if (w_count !== 4'd0 || bus_w.rd_valid !== 1'b0) begin failures++; $display("FAIL pass_drained got=%0d exp=0", w_count); end
  endtask

  task automatic test_halt_fail();
    do_clear();
    retire(0, 1, 0, 0);
    retire(1, 2, 1, 0);
    retire(2, 3, 2, 0);
    retire(3, 3, 7, 0);
    retire(3, 3, 7, 7);
    checks++; if (w_state !== 3'd3) begin failures++; $display("FAIL fail_state got=%0d exp=3", w_state); end
    checks++; if (w_done !== 1'b1 || w_pass !== 1'b0) begin failures++; $display("FAIL fail_done_pass got=%b%b exp=10", w_done, w_pass); end
  endtask

  task automatic test_timeout();
    do_clear();
    retire(10, 10, 3, 0);
    checks++; if (w_state !== 3'd1) begin failures++; $display("FAIL tmo_pend got=%0d exp=1", w_state); end
    retire(10, 11, 3, 0);
    checks++; if (w_state !== 3'd0) begin failures++; $display("FAIL tmo_back_run got=%0d exp=0", w_state); end
    for (int i = 0; i < 200 && m_state <= 1; i++) begin
      en = 1'($urandom);
      pc = PC_W'($urandom);
      next_pc = pc + PC_W'(1);
      instr = INSTR_W'($urandom);
      rd_en = 1'($urandom);
      tick();
      checks++;
      if (w_state !== 3'(m_state) || w_count !== 4'(q_w.size())) begin
        failures++;
        $display("FAIL tmo_step state=%0d exp=%0d count=%0d exp=%0d", w_state, m_state, w_count, q_w.size());
      end
    end
    en = 1'b0; rd_en = 1'b0;
    checks++; if (w_state !== 3'd4) begin failures++; $display("FAIL tmo_state got=%0d exp=4", w_state); end
    checks++; if (w_cycle !== 16'd100) begin failures++; $display("FAIL tmo_cycle got=%0d exp=100", w_cycle); end
    checks++; if (w_done !== 1'b1 || w_pass !== 1'b0) begin failures++; $display("FAIL tmo_done_pass got=%b%b exp=10", w_done, w_pass); end
  endtask

  task automatic test_same_edge();
    do_clear();
    repeat (98) tick();
    retire(20, 20, 5, 0);
    checks++; if (w_state !== 3'd1 || w_cycle !== 16'd99) begin failures++; $display("FAIL edge_pend state=%0d cycle=%0d exp=1/99", w_state, w_cycle); end
    retire(20, 20, 5, 0);
    checks++; if (w_state !== 3'd2) begin failures++; $display("FAIL edge_halt_wins got=%0d exp=2", w_state); end
  endtask

  task automatic test_overflow();
    entry_t ex [10];
    do_clear();
    for (int i = 0; i < 10; i++) begin
      retire(100 + i, 200 + i, i % 16, 0);
      ex[i] = {pc, instr, zero_flag};
    end
    checks++; if (w_count !== 4'd8 || w_ovf !== 1'b1) begin failures++; $display("FAIL ovf_wrap count=%0d ovf=%b exp=8/1", w_count, w_ovf); end
    checks++; if (n_count !== 4'd8 || n_ovf !== 1'b1) begin failures++; $display("FAIL ovf_drop count=%0d ovf=%b exp=8/1", n_count, n_ovf); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus_w.rd_data !== ex[i+2]) begin failures++; $display("FAIL ovf_wrap_pop[%0d] got=%h exp=%h", i, bus_w.rd_data, ex[i+2]); end
      checks++; if (bus_n.rd_data !== ex[i]) begin failures++; $display("FAIL ovf_drop_pop[%0d] got=%h exp=%h", i, bus_n.rd_data, ex[i]); end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    checks++; if (w_count !== 4'd0 || n_count !== 4'd0) begin failures++; $display("FAIL ovf_empty got=%0d/%0d exp=0", w_count, n_count); end
    checks++; if (w_ovf !== 1'b1 || n_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b%b exp=11", w_ovf, n_ovf); end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 8; i++) retire(300 + i, 400 + i, 1, 0);
    checks++; if (w_count !== 4'd8 || w_ovf !== 1'b0) begin failures++; $display("FAIL full_fill count=%0d ovf=%b exp=8/0", w_count, w_ovf); end
    for (int k = 0; k < 4; k++) begin
      en = 1'b1; rd_en = 1'b1;
      pc = PC_W'(500 + k); next_pc = PC_W'(600 + k); instr = INSTR_W'($urandom);
      tick();
      checks++;
      if (w_count !== 4'd8 || n_count !== 4'd8 || w_ovf !== 1'b0 || n_ovf !== 1'b0) begin
        failures++;
        $display("FAIL full_pushpop[%0d] count=%0d/%0d ovf=%b%b exp=8/8 00", k, w_count, n_count, w_ovf, n_ovf);
      end
      checks++;
      if (bus_w.rd_data !== q_w[0] || bus_n.rd_data !== q_n[0]) begin
        failures++;
        $display("FAIL full_pushpop_data[%0d] got=%h exp=%h", k, bus_w.rd_data, q_w[0]);
      end
    end
    en = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (w_count !== 4'd0 || bus_w.rd_valid !== 1'b0 || bus_w.rd_data !== '0 || w_ovf !== 1'b0) begin
        failures++;
        $display("FAIL empty_rd_en[%0d] count=%0d valid=%b data=%h exp=0", k, w_count, bus_w.rd_valid, bus_w.rd_data);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_random();
    entry_t exp_w, exp_n;
    do_clear();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(3) != 0);
      pc = PC_W'($urandom_range(15));
      next_pc = ($urandom_range(5) == 0) ? pc : pc + PC_W'($urandom_range(3) + 1);
      instr = INSTR_W'($urandom);
      zero_flag = 1'($urandom);
      check_val = ($urandom_range(1) == 0) ? '0 : DATA_W'($urandom_range(3));
      rd_en = ($urandom_range(2) == 0);
      clear = ($urandom_range(79) == 0);
      tick();
      clear = 1'b0;
      exp_w = (q_w.size() != 0) ? q_w[0] : '0;
      exp_n = (q_n.size() != 0) ? q_n[0] : '0;
      checks++;
      if (w_state !== 3'(m_state) || n_state !== 3'(m_state)) begin
        failures++; $display("FAIL rnd_state[%0d] got=%0d/%0d exp=%0d", i, w_state, n_state, m_state);
      end
      checks++;
      if (w_count !== 4'(q_w.size()) || n_count !== 4'(q_n.size())) begin
        failures++; $display("FAIL rnd_count[%0d] got=%0d/%0d exp=%0d/%0d", i, w_count, n_count, q_w.size(), q_n.size());
      end
      checks++;
      if (bus_w.rd_data !== exp_w || bus_n.rd_data !== exp_n) begin
        failures++; $display("FAIL rnd_data[%0d] got=%h/%h exp=%h/%h", i, bus_w.rd_data, bus_n.rd_data, exp_w, exp_n);
      end
      checks++;
      if (w_ovf !== m_ovf_w || n_ovf !== m_ovf_n) begin
        failures++; $display("FAIL rnd_ovf[%0d] got=%b%b exp=%b%b", i, w_ovf, n_ovf, m_ovf_w, m_ovf_n);
      end
      checks++;
      if (w_cycle !== CNT_W'(m_cycle) || w_done !== (m_state >= 2) || w_pass !== (m_state == 2)) begin
        failures++; $display("FAIL rnd_cycle[%0d] got=%0d done=%b pass=%b exp=%0d", i, w_cycle, w_done, w_pass, m_cycle);
      end
    end
    en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    retire(0, 1, 0, 0);
    retire(1, 2, 1, 0);
    retire(2, 2, 2, 0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (w_state !== 3'd0 || w_count !== 4'd0 || w_cycle !== '0) begin failures++; $display("FAIL areset_state state=%0d count=%0d cycle=%0d exp=0", w_state, w_count, w_cycle); end
    checks++; if (bus_w.rd_valid !== 1'b0 || bus_w.rd_data !== '0) begin failures++; $display("FAIL areset_read valid=%b data=%h exp=0", bus_w.rd_valid, bus_w.rd_data); end
    model_reset();
    rst = 1'b1;
    retire(7, 7, 4, 0);
    checks++; if (w_state !== 3'd1) begin failures++; $display("FAIL areset_fresh_run got=%0d exp=1", w_state); end
    retire(7, 7, 4, 0);
    checks++; if (w_state !== 3'd2) begin failures++; $display("FAIL areset_pass got=%0d exp=2", w_state); end
    do_clear();
    checks++; if (w_state !== 3'd0 || w_done !== 1'b0 || w_count !== 4'd0 || w_cycle !== '0) begin failures++; $display("FAIL clear_after_pass state=%0d done=%b count=%0d exp=0", w_state, w_done, w_count); end
  endtask

  task automatic test_hist();
    do_clear();
    retire(0, 1, 0, 0);
    retire(1, 2, 0, 0);
    retire(2, 3, 0, 0);
    retire(3, 9, 7, 0);
`ifdef CPU_TRACE_MONITOR_OPCODE_HIST_EN
    hist_sel = 4'd0; #1;
    checks++; if (w_hist !== 16'd3) begin failures++; $display("FAIL hist_add got=%0d exp=3", w_hist); end
    hist_sel = 4'd7; #1;
    checks++; if (w_hist !== 16'd1) begin failures++; $display("FAIL hist_jmp got=%0d exp=1", w_hist); end
    hist_sel = 4'd5; #1;
    checks++; if (w_hist !== 16'd0) begin failures++; $display("FAIL hist_empty got=%0d exp=0", w_hist); end
`else
    for (int s = 0; s < 16; s += 7) begin
      hist_sel = 4'(s); #1;
      checks++; if (w_hist !== '0 || n_hist !== '0) begin failures++; $display("FAIL hist_tied[%0d] got=%0d exp=0", s, w_hist); end
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_halt_pass();
    test_halt_fail();
    test_timeout();
    test_same_edge();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_async_reset();
    test_hist();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
